// File: rtl/hazard_pkg.sv
// Shared types for the hazard tracker: per-stage control/tag bundle carried D->E->M->W.
package hazard_pkg;

  localparam int RA_W_DEFAULT = 4;

  typedef struct packed {
    logic                    valid;
    logic                    regwrite;
    logic                    memtoreg;
    logic                    pcsrc;
    logic                    branch;
    logic [RA_W_DEFAULT-1:0] wa;
  } stage_ctrl_t;

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage register of stage_ctrl_t with sync reset, clear (bubble) and enable.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  stage_ctrl_t d,
  output stage_ctrl_t q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// Producer side of the pipeline hazard handshake: carries dest tags/controls D->E->M->W,
// reports tag matches and pending writes, applies StallD/FlushD/FlushE, counts stalls/flushes.
module hazard_tracker
  import hazard_pkg::*;
#(
  parameter int RA_W   = RA_W_DEFAULT,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RA_W-1:0]   RA1D,
  input  logic [RA_W-1:0]   RA2D,
  input  logic [RA_W-1:0]   WA3D,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              PCSrcD,
  input  logic              BranchD,
  input  logic              CondExE,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  output logic              Match_1E_M,
  output logic              Match_1E_W,
  output logic              Match_2E_M,
  output logic              Match_2E_W,
  output logic              Match_12D_E,
  output logic              RegWriteM,
  output logic              RegWriteW,
  output logic              MemtoRegE,
  output logic              PCSrcW,
  output logic              PCWrPendingF,
  output logic              BranchTakenE,
  output logic [STAT_W-1:0] StallCnt,
  output logic [STAT_W-1:0] FlushCnt
);

  // Stall/flush contract: the hazard unit samples our Match_*/pending outputs combinationally
  // and returns StallD/FlushD/FlushE, which only take effect at the next rising edge.
  logic            valid_d;
  logic [RA_W-1:0] ra1_e;
  logic [RA_W-1:0] ra2_e;
  stage_ctrl_t     e_d, e_q, m_d, m_q, w_q;
  logic            unused_w_bits;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_d <= 1'b0;
    end else if (FlushD) begin
      valid_d <= 1'b0;
    end else if (!StallD) begin
      valid_d <= 1'b1;
    end
  end

  // Source tags only matter in E; their content during a flushed E is don't-care.
  always_ff @(posedge clk) begin
    if (reset) begin
      ra1_e <= '0;
      ra2_e <= '0;
    end else begin
      ra1_e <= RA1D;
      ra2_e <= RA2D;
    end
  end

  always_comb begin
    e_d          = '0;
    e_d.valid    = valid_d;
    e_d.regwrite = RegWriteD & valid_d;
    e_d.memtoreg = MemtoRegD & valid_d;
    e_d.pcsrc    = PCSrcD & valid_d;
    e_d.branch   = BranchD & valid_d;
    e_d.wa       = WA3D;

    m_d          = '0;
    m_d.valid    = e_q.valid;
    m_d.regwrite = e_q.regwrite & CondExE & e_q.valid;
    m_d.memtoreg = e_q.memtoreg & CondExE & e_q.valid;
    m_d.pcsrc    = e_q.pcsrc & CondExE & e_q.valid;
    m_d.branch   = e_q.branch & e_q.valid;
    m_d.wa       = e_q.wa;
  end

  hazard_stage_reg u_stage_e (
    .clk   (clk),
    .reset (reset),
    .clear (FlushE),
    .en    (1'b1),
    .d     (e_d),
    .q     (e_q)
  );

  hazard_stage_reg u_stage_m (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .en    (1'b1),
    .d     (m_d),
    .q     (m_q)
  );

  hazard_stage_reg u_stage_w (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .en    (1'b1),
    .d     (m_q),
    .q     (w_q)
  );

  // Matches are deliberately not gated by RegWrite; the hazard unit does that.
  assign Match_1E_M  = e_q.valid & m_q.valid & (ra1_e == m_q.wa);
  assign Match_1E_W  = e_q.valid & w_q.valid & (ra1_e == w_q.wa);
  assign Match_2E_M  = e_q.valid & m_q.valid & (ra2_e == m_q.wa);
  assign Match_2E_W  = e_q.valid & w_q.valid & (ra2_e == w_q.wa);
  assign Match_12D_E = valid_d & e_q.valid & ((RA1D == e_q.wa) | (RA2D == e_q.wa));

  assign RegWriteM    = m_q.regwrite;
  assign RegWriteW    = w_q.regwrite;
  assign PCSrcW       = w_q.pcsrc;
  assign MemtoRegE    = e_q.valid & e_q.memtoreg;
  assign BranchTakenE = e_q.valid & e_q.branch & CondExE;
  // The E term ignores CondExE on purpose: fetch stalls conservatively until E resolves.
  assign PCWrPendingF = (valid_d & PCSrcD) | (e_q.valid & e_q.pcsrc) | m_q.pcsrc;

  assign unused_w_bits = w_q.memtoreg ^ w_q.branch;

  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallD && (StallCnt != '1)) StallCnt <= StallCnt + STAT_W'(1);
      if (FlushE && (FlushCnt != '1)) FlushCnt <= FlushCnt + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed pipeline scenarios plus randomized
// traffic against an instruction-level reference model; a STAT_W=2 copy covers saturation.
module tb_hazard_tracker;

  localparam int RA_W = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [RA_W-1:0] RA1D, RA2D, WA3D;
  logic            RegWriteD, MemtoRegD, PCSrcD, BranchD, CondExE;
  logic            StallD, FlushD, FlushE;
  logic            Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic            RegWriteM, RegWriteW, MemtoRegE, PCSrcW, PCWrPendingF, BranchTakenE;
  logic [15:0]     StallCnt, FlushCnt;
  logic [1:0]      stall_cnt2, flush_cnt2;
  logic [10:0]     d2_unused;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_tracker dut (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD), .BranchD(BranchD),
    .CondExE(CondExE), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W), .Match_2E_M(Match_2E_M),
    .Match_2E_W(Match_2E_W), .Match_12D_E(Match_12D_E), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .PCSrcW(PCSrcW),
    .PCWrPendingF(PCWrPendingF), .BranchTakenE(BranchTakenE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  hazard_tracker #(.STAT_W(2)) dut2 (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD), .BranchD(BranchD),
    .CondExE(CondExE), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .Match_1E_M(d2_unused[0]), .Match_1E_W(d2_unused[1]), .Match_2E_M(d2_unused[2]),
    .Match_2E_W(d2_unused[3]), .Match_12D_E(d2_unused[4]), .RegWriteM(d2_unused[5]),
    .RegWriteW(d2_unused[6]), .MemtoRegE(d2_unused[7]), .PCSrcW(d2_unused[8]),
    .PCWrPendingF(d2_unused[9]), .BranchTakenE(d2_unused[10]),
    .StallCnt(stall_cnt2), .FlushCnt(flush_cnt2)
  );

  // ---------------- clock / drive helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa,
                       input logic rw, input logic mr, input logic pc, input logic br);
    RA1D = ra1; RA2D = ra2; WA3D = wa;
    RegWriteD = rw; MemtoRegD = mr; PCSrcD = pc; BranchD = br;
  endtask

  task automatic hz(input logic st, input logic fd, input logic fe, input logic cond);
    StallD = st; FlushD = fd; FlushE = fe; CondExE = cond;
  endtask

  // ---------------- reference model: instructions in flight ----------------
  typedef struct {
    bit       v;     // a real instruction occupies the slot
    bit       ex;    // its condition passed in E
    bit       rw, mr, pc, br;
    bit [3:0] ra1, ra2, wa;
  } ins_t;

  bit   mod_vd;
  ins_t mod_e, mod_m, mod_w;
  int   mod_stalls, mod_flushes;

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    hz(0, 0, 0, 0);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    total++;
    if ({Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} !== 5'b0) begin
      bad++;
      $display("FAIL reset_matches got=%b exp=00000",
               {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E});
    end
    total++;
    if ({RegWriteM, RegWriteW, MemtoRegE, PCSrcW, PCWrPendingF, BranchTakenE} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrls got=%b exp=000000",
               {RegWriteM, RegWriteW, MemtoRegE, PCSrcW, PCWrPendingF, BranchTakenE});
    end
    total++;
    if (StallCnt !== 16'd0 || FlushCnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_cnts got=%0d/%0d exp=0/0", StallCnt, FlushCnt);
    end
    tick();  // D becomes valid, E still empty
    hz(0, 0, 0, 1);
    #1;
    total++;
    if (Match_12D_E !== 1'b0) begin
      bad++;
      $display("FAIL reset_e_empty match_12d_e got=%b exp=0", Match_12D_E);
    end
  endtask

  task automatic test_raw_m();
    drive(2, 3, 1, 1, 0, 0, 0);   // ADD r1,r2,r3
    tick();
    drive(1, 3, 2, 1, 0, 0, 0);   // SUB r2,r1,r3
    #1;
    total++;
    if (Match_12D_E !== 1'b1) begin
      bad++;
      $display("FAIL raw_d_e match_12d_e got=%b exp=1", Match_12D_E);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (Match_1E_M !== 1'b1 || RegWriteM !== 1'b1 || Match_2E_M !== 1'b0) begin
      bad++;
      $display("FAIL raw_e_m m1/rwm/m2 got=%b%b%b exp=110", Match_1E_M, RegWriteM, Match_2E_M);
    end
    tick();
    #1;
    total++;
    if (Match_1E_W !== 1'b0 || RegWriteW !== 1'b1) begin
      bad++;
      $display("FAIL raw_nop_w m1w/rww got=%b%b exp=01", Match_1E_W, RegWriteW);
    end
  endtask

  task automatic test_load_use_stall();
    drive(6, 7, 4, 1, 1, 0, 0);   // LDR r4,[r6,r7]
    tick();
    drive(4, 4, 5, 1, 0, 0, 0);   // ADD r5,r4,r4
    hz(1, 0, 1, 1);
    #1;
    total++;
    if (Match_12D_E !== 1'b1 || MemtoRegE !== 1'b1) begin
      bad++;
      $display("FAIL ldu_detect m12/mre got=%b%b exp=11", Match_12D_E, MemtoRegE);
    end
    tick();
    hz(0, 0, 0, 1);
    #1;
    total++;
    if (MemtoRegE !== 1'b0 || Match_12D_E !== 1'b0 || RegWriteM !== 1'b1) begin
      bad++;
      $display("FAIL ldu_bubble mre/m12/rwm got=%b%b%b exp=001", MemtoRegE, Match_12D_E, RegWriteM);
    end
    total++;
    if (StallCnt !== 16'd1 || FlushCnt !== 16'd1) begin
      bad++;
      $display("FAIL ldu_counts got=%0d/%0d exp=1/1", StallCnt, FlushCnt);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (Match_1E_W !== 1'b1 || Match_2E_W !== 1'b1 || Match_1E_M !== 1'b0) begin
      bad++;
      $display("FAIL ldu_replay m1w/m2w/m1m got=%b%b%b exp=110", Match_1E_W, Match_2E_W, Match_1E_M);
    end
  endtask

  task automatic test_branch();
    drive(0, 0, 0, 0, 0, 0, 1);   // B taken
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    hz(0, 1, 1, 1);
    #1;
    total++;
    if (BranchTakenE !== 1'b1) begin
      bad++;
      $display("FAIL br_taken got=%b exp=1", BranchTakenE);
    end
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);   // wrong-path PC write must be ignored while D is invalid
    hz(0, 0, 0, 1);
    #1;
    total++;
    if (PCWrPendingF !== 1'b0 || BranchTakenE !== 1'b0 || FlushCnt !== 16'd2) begin
      bad++;
      $display("FAIL br_flushed pend/bt/fcnt got=%b%b/%0d exp=00/2", PCWrPendingF, BranchTakenE, FlushCnt);
    end
    tick();
    drive(0, 0, 6, 1, 0, 0, 1);   // BL-like, condition fails
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    hz(0, 0, 0, 0);
    #1;
    total++;
    if (BranchTakenE !== 1'b0) begin
      bad++;
      $display("FAIL br_not_taken got=%b exp=0", BranchTakenE);
    end
    tick();
    hz(0, 0, 0, 1);
    #1;
    total++;
    if (RegWriteM !== 1'b0) begin
      bad++;
      $display("FAIL br_cond_kill regwritem got=%b exp=0", RegWriteM);
    end
  endtask

  task automatic test_pc_write();
    logic [3:0] exp_pend;
    logic [3:0] exp_pcw;
    exp_pend = 4'b0111;
    exp_pcw  = 4'b1000;
    drive(0, 0, 15, 0, 0, 1, 0);  // MOV pc
    hz(0, 0, 0, 1);
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c < 4) begin
        total++;
        if (PCWrPendingF !== exp_pend[c]) begin
          bad++;
          $display("FAIL pc_pending cyc=%0d got=%b exp=%b", c, PCWrPendingF, exp_pend[c]);
        end
      end
      total++;
      if (PCSrcW !== ((c < 4) ? exp_pcw[c] : 1'b0)) begin
        bad++;
        $display("FAIL pc_srcw cyc=%0d got=%b exp=%b", c, PCSrcW, (c < 4) ? exp_pcw[c] : 1'b0);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_random();
    logic [10:0] exp_flags, obs_flags;
    ins_t        empty;
    empty = '{default: 0};
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    hz(0, 0, 0, 0);
    tick();
    mod_vd = 0; mod_e = empty; mod_m = empty; mod_w = empty;
    mod_stalls = 0; mod_flushes = 0;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      hz(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
         ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      #1;
      exp_flags = {
        mod_e.v & mod_m.v & (mod_e.ra1 == mod_m.wa),
        mod_e.v & mod_w.v & (mod_e.ra1 == mod_w.wa),
        mod_e.v & mod_m.v & (mod_e.ra2 == mod_m.wa),
        mod_e.v & mod_w.v & (mod_e.ra2 == mod_w.wa),
        mod_vd & mod_e.v & ((RA1D == mod_e.wa) | (RA2D == mod_e.wa)),
        mod_m.v & mod_m.ex & mod_m.rw,
        mod_w.v & mod_w.ex & mod_w.rw,
        mod_e.v & mod_e.mr,
        mod_w.v & mod_w.ex & mod_w.pc,
        (mod_vd & PCSrcD) | (mod_e.v & mod_e.pc) | (mod_m.v & mod_m.ex & mod_m.pc),
        mod_e.v & mod_e.br & CondExE};
      obs_flags = {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
                   RegWriteM, RegWriteW, MemtoRegE, PCSrcW, PCWrPendingF, BranchTakenE};
      total++;
      if (obs_flags !== exp_flags) begin
        bad++;
        $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, obs_flags, exp_flags);
      end
      total++;
      if (StallCnt !== 16'(sat(mod_stalls, 65535)) || FlushCnt !== 16'(sat(mod_flushes, 65535))) begin
        bad++;
        $display("FAIL rnd_cnt16 n=%0d got=%0d/%0d exp=%0d/%0d", n, StallCnt, FlushCnt,
                 sat(mod_stalls, 65535), sat(mod_flushes, 65535));
      end
      total++;
      if (stall_cnt2 !== 2'(sat(mod_stalls, 3)) || flush_cnt2 !== 2'(sat(mod_flushes, 3))) begin
        bad++;
        $display("FAIL rnd_cnt2 n=%0d got=%0d/%0d exp=%0d/%0d", n, stall_cnt2, flush_cnt2,
                 sat(mod_stalls, 3), sat(mod_flushes, 3));
      end
      // advance the model by one clock
      if (reset) begin
        mod_vd = 0; mod_e = empty; mod_m = empty; mod_w = empty;
        mod_stalls = 0; mod_flushes = 0;
      end else begin
        mod_w    = mod_m;
        mod_m    = mod_e;
        mod_m.ex = CondExE;
        if (FlushE) mod_e = empty;
        else mod_e = '{v: mod_vd, ex: 0, rw: RegWriteD, mr: MemtoRegD, pc: PCSrcD,
                       br: BranchD, ra1: RA1D, ra2: RA2D, wa: WA3D};
        if (FlushD) mod_vd = 0;
        else if (!StallD) mod_vd = 1;
        mod_stalls  += int'(StallD);
        mod_flushes += int'(FlushE);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    int exp2 [5] = '{1, 2, 3, 3, 3};
    reset = 1'b1;
    hz(0, 0, 0, 1);
    tick();
    reset = 1'b0;
    StallD = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (stall_cnt2 !== 2'(exp2[c]) || StallCnt !== 16'(c + 1)) begin
        bad++;
        $display("FAIL sat_count cyc=%0d got=%0d/%0d exp=%0d/%0d", c, stall_cnt2, StallCnt,
                 exp2[c], c + 1);
      end
    end
    reset = 1'b1;
    tick();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;  // reset at the third stalled cycle
    tick();
    reset = 1'b0;
    StallD = 1'b0;
    #1;
    total++;
    if (stall_cnt2 !== 2'd0 || StallCnt !== 16'd0) begin
      bad++;
      $display("FAIL sat_reset got=%0d/%0d exp=0/0", stall_cnt2, StallCnt);
    end
  endtask

  initial begin
    test_reset();
    test_raw_m();
    test_load_use_stall();
    test_branch();
    test_pc_write();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
